dmem_lane_ctrl: RTL and testbench
=================================

// Module: dmem_lane_ctrl
// PURPOSE
// Parametrised byte-addressed RV32I data memory with a valid/ready request/response interface.
// Stores write only the addressed byte lanes (SB/SH/SW); loads extract and sign/zero-extend
// (LB/LH/LW/LBU/LHU). Misaligned and illegal F3 accesses are flagged, not executed.
// Sits between the EX/MEM stage and the word-wide SRAM array; one transaction in flight.
// PARAMETERS
// ADDR_W    12  byte-address width; array holds 2**(ADDR_W-2) 32-bit words
// READ_LAT  1   load latency in cycles, legal values 1 or 2 (2 adds output register stage)
// PORTS
// clk        in   1       rising-edge clock
// rst_n      in   1       asynchronous active-low reset
// req_valid  in   1       request present
// req_ready  out  1       block can accept request (high only in IDLE)
// req_we     in   1       1 = store, 0 = load
// req_f3     in   3       RV32I funct3 (size/sign)
// req_addr   in   ADDR_W  byte address
// req_wdata  in   32      store data, right-aligned (lane 0 = bits 7:0)
// rsp_valid  out  1       response present; held until rsp_ready
// rsp_ready  in   1       consumer takes response
// rsp_rdata  out  32      load result, extended; 0 for stores and errors
// rsp_err    out  1       1 = misaligned or illegal F3; access not performed
// BEHAVIOUR
// Reset: clk single clock; rst_n asynchronous, active-low. On assert: state=IDLE, rsp_valid=0,
//   rsp_rdata=0, rsp_err=0, req_ready=1 after deassert. Memory array NOT reset.
// FSM: IDLE -> (accept load, ok) RD -> RESP; IDLE -> (accept store or error) RESP;
//   RD stays READ_LAT-1 cycles then RESP; RESP -> IDLE on rsp_valid & rsp_ready.
// Accept = req_valid & req_ready. Request fields sampled at the accept edge only.
// Word index = req_addr[ADDR_W-1:2]; lane offset = req_addr[1:0].
// Legal: LB/LBU/SB any offset; LH/LHU/SH offset[0]=0; LW/SW offset=0.
//   Loads with F3 in {011,110,111}, stores with F3>=011 -> illegal.
// Error: no array write, rsp_err=1, rsp_rdata=0, rsp_valid in cycle after accept.
// Store: write at accept edge with byte enables: SB 1<<off, SH 3<<off, SW 4'hF;
//   data replicated to lanes (SB {4{d[7:0]}}, SH {2{d[15:0]}}); unselected lanes unchanged.
//   rsp_valid=1, rsp_err=0, rsp_rdata=0 in cycle after accept.
// Load: array read launched at accept edge; rsp_valid asserts READ_LAT cycles after accept
//   cycle. Lane select by offset; LB/LH sign-extend from bit 7/15 of selected lane; LBU/LHU zero.
// Back-to-back: next accept earliest in cycle after rsp handshake (req_ready=0 in RD/RESP).
// rsp_rdata/rsp_err stable while rsp_valid=1 and rsp_ready=0.
// Reset mid-operation: in-flight load discarded, no response; store already written persists.
// Address wrap: none; all ADDR_W-bit addresses valid words.
// TESTING
// 1 SW 0x8000_0001 @0x10; LW @0x10 -> rsp_rdata=0x8000_0001, rsp_err=0, READ_LAT cycles after accept.
// 2 SW 0xAABBCCDD @0x20; SB 0x11 @0x22; LW @0x20 -> 0xAA11CCDD (other lanes preserved).
// 3 Word 0x80FF7F01 @0x30: LB @0x33 -> 0xFFFFFF80; LBU @0x33 -> 0x00000080; LH @0x32 -> 0xFFFF80FF;
//   LHU @0x30 -> 0x00007F01.
// 4 LW @0x31, SH @0x33, LD f3=011 -> rsp_err=1, rsp_rdata=0; follow-up LW shows memory unchanged.
// 5 Load with rsp_ready=0 for 5 cycles -> rsp_valid/rdata held, req_ready=0; accept resumes after
//   handshake.
// 6 Assert rst_n=0 during RD -> rsp_valid=0 immediately, no response after release; run with
//   READ_LAT=1 and 2.

Source files
------------

// File: rtl/dmem_lane_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_ctrl_if
// Purpose  : Request/response bundle between the EX/MEM stage (master) and
//            the byte-lane data memory controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_lane_ctrl_if #(
    parameter int ADDR_W = 12
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_f3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_f3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_f3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_ctrl
// Purpose  : Byte-addressed RV32I data memory. Stores update only the
//            addressed byte lanes, loads extract and sign/zero-extend.
//            Misaligned or illegal-funct3 accesses are answered with an
//            error and never touch the array. One transaction in flight.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 1      // 1 or 2; 2 adds an output register stage
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_lane_ctrl_if.slave bus
);
    localparam int         c_depth = 2 ** (ADDR_W - 2);
    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0] mem_q [c_depth];
    logic [31:0] word_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        load_q;
    logic        err_q;

    logic              w_accept;
    logic              w_legal;
    logic              w_store_ok;
    logic              w_load_ok;
    logic              w_load_rsp;
    logic [ADDR_W-3:0] w_idx;
    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_rep;
    logic [31:0]       w_shift;
    logic [31:0]       w_ext;

    assign w_accept   = bus.req_valid & bus.req_ready;
    assign w_idx      = bus.req_addr[ADDR_W-1:2];
    assign w_off      = bus.req_addr[1:0];
    assign w_store_ok = w_accept &  bus.req_we & w_legal;
    assign w_load_ok  = w_accept & ~bus.req_we & w_legal;

    // Alignment and funct3 legality of the presented request
    always_comb begin
        w_legal = 1'b0;
        case (bus.req_f3)
            c_f3_b:  w_legal = 1'b1;
            c_f3_h:  w_legal = ~w_off[0];
            c_f3_w:  w_legal = (w_off == 2'b00);
            c_f3_bu: w_legal = ~bus.req_we;
            c_f3_hu: w_legal = ~bus.req_we & ~w_off[0];
            default: w_legal = 1'b0;
        endcase
    end

    // Lane enables and lane-replicated store data (size from funct3[1:0])
    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = bus.req_wdata;
        case (bus.req_f3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << w_off;
                w_wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = 4'b0011 << w_off;
                w_wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            default: w_be = 4'b1111;
        endcase
    end

    // Word array: lane-masked write and read launch, both at the accept edge; never reset
    always_ff @(posedge clk) begin
        if (w_store_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem_q[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                end
            end
        end
        if (w_load_ok) begin
            word_q <= mem_q[w_idx];
        end
    end

    // State register and transaction attributes captured at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                f3_q   <= bus.req_f3;
                off_q  <= w_off;
                load_q <= ~bus.req_we;
                err_q  <= ~w_legal;
            end
        end
    end

    // Next-state: legal loads wait in RD for the extra latency stage only when READ_LAT is 2
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = (w_load_ok && (READ_LAT > 1)) ? S_RD : S_RESP;
                end
            end
            S_RD:    state_d = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_err   = (state_q == S_RESP) & err_q;
    assign w_load_rsp    = load_q & ~err_q;

    // Lane select and sign/zero extension of the fetched word
    assign w_shift = word_q >> {off_q, 3'b000};
    always_comb begin
        w_ext = w_shift;
        case (f3_q)
            c_f3_b:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            c_f3_h:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            c_f3_bu: w_ext = {24'd0, w_shift[7:0]};
            c_f3_hu: w_ext = {16'd0, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    generate
        if (READ_LAT > 1) begin : g_lat2
            logic [31:0] rdata_q;
            // Output stage: loaded during RD, zeroed for every new transaction
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (w_accept) begin
                    rdata_q <= '0;
                end else if ((state_q == S_RD) && w_load_rsp) begin
                    rdata_q <= w_ext;
                end
            end
            assign bus.rsp_rdata = rdata_q;
        end else begin : g_lat1
            assign bus.rsp_rdata = ((state_q == S_RESP) && w_load_rsp) ? w_ext : '0;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_dmem_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lane_ctrl
// Purpose  : Self-checking bench for dmem_lane_ctrl. Two instances
//            (READ_LAT 1 and 2) are exercised one at a time against a
//            byte-array reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lane_ctrl;
    logic clk;
    logic rst_n;

    bit          sel;            // 0 -> READ_LAT=1 instance, 1 -> READ_LAT=2 instance
    logic        t_req_valid;
    logic        t_we;
    logic [2:0]  t_f3;
    logic [11:0] t_addr;
    logic [31:0] t_wdata;
    logic        t_rsp_ready;

    int tests = 0;
    int fails = 0;

    logic [7:0] mref [0:1][0:4095];

    dmem_lane_ctrl_if #(.ADDR_W(12)) bus_l1 ();
    dmem_lane_ctrl_if #(.ADDR_W(12)) bus_l2 ();

    assign bus_l1.req_valid = t_req_valid & ~sel;
    assign bus_l2.req_valid = t_req_valid &  sel;
    assign bus_l1.rsp_ready = t_rsp_ready & ~sel;
    assign bus_l2.rsp_ready = t_rsp_ready &  sel;
    assign bus_l1.req_we    = t_we;
    assign bus_l2.req_we    = t_we;
    assign bus_l1.req_f3    = t_f3;
    assign bus_l2.req_f3    = t_f3;
    assign bus_l1.req_addr  = t_addr;
    assign bus_l2.req_addr  = t_addr;
    assign bus_l1.req_wdata = t_wdata;
    assign bus_l2.req_wdata = t_wdata;

    dmem_lane_ctrl #(.ADDR_W(12), .READ_LAT(1)) dut_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l1)
    );

    dmem_lane_ctrl #(.ADDR_W(12), .READ_LAT(2)) dut_l2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l2)
    );

    logic        cur_req_ready;
    logic        cur_rsp_valid;
    logic        cur_rsp_err;
    logic [31:0] cur_rsp_rdata;
    assign cur_req_ready = sel ? bus_l2.req_ready : bus_l1.req_ready;
    assign cur_rsp_valid = sel ? bus_l2.rsp_valid : bus_l1.rsp_valid;
    assign cur_rsp_err   = sel ? bus_l2.rsp_err   : bus_l1.rsp_err;
    assign cur_rsp_rdata = sel ? bus_l2.rsp_rdata : bus_l1.rsp_rdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Access is legal when funct3 names a real size and the address is size-aligned
    function automatic bit legal(input bit we, input logic [2:0] f3, input logic [11:0] a);
        int n;
        n = 1 << f3[1:0];
        if (we && f3 > 3'd2) return 1'b0;
        if (!we && (f3[1:0] == 2'd3 || f3 == 3'd6)) return 1'b0;
        return (int'(a) % n) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [11:0] a);
        int n;
        logic [31:0] v;
        n = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mref[sel][int'(a) + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic void model_store(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) mref[sel][int'(a) + i] = wd[8*i +: 8];
    endfunction

    // One complete request/response exchange; starts and ends at a falling edge
    task automatic do_txn(input bit we, input logic [2:0] f3, input logic [11:0] addr,
                          input logic [31:0] wd, input int hold, output logic [31:0] got);
        bit          ok;
        int          lat;
        int          exp_lat;
        logic [31:0] exp_rd;
        ok      = legal(we, f3, addr);
        exp_rd  = (ok && !we) ? model_load(f3, addr) : 32'd0;
        exp_lat = (ok && !we) ? (sel ? 2 : 1) : 1;
        if (ok && we) model_store(f3, addr, wd);

        chk("req_ready_idle", 32'(cur_req_ready), 32'd1);
        t_we = we; t_f3 = f3; t_addr = addr; t_wdata = wd;
        t_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_req_valid = 1'b0;
        t_we    = ~we;
        t_f3    = 3'($urandom_range(0, 7));
        t_addr  = 12'($urandom());
        t_wdata = $urandom();

        lat = 1;
        while (!cur_rsp_valid && lat < 8) begin
            chk("req_ready_busy", 32'(cur_req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("rsp_valid", 32'(cur_rsp_valid), 32'd1);
        chk("rsp_rdata", cur_rsp_rdata, exp_rd);
        chk("rsp_err", 32'(cur_rsp_err), 32'(!ok));
        got = cur_rsp_rdata;

        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(cur_rsp_valid), 32'd1);
            chk("hold_rdata", cur_rsp_rdata, exp_rd);
            chk("hold_err", 32'(cur_rsp_err), 32'(!ok));
            chk("hold_req_ready", 32'(cur_req_ready), 32'd0);
        end

        t_rsp_ready = 1'b1;
        @(negedge clk);
        t_rsp_ready = 1'b0;
        chk("post_hs_valid", 32'(cur_rsp_valid), 32'd0);
        chk("post_hs_req_ready", 32'(cur_req_ready), 32'd1);
    endtask

    // Reset during a store response and during an in-flight load
    task automatic reset_mid(input logic [11:0] addr);
        logic [31:0] d;
        logic [31:0] got;
        d = $urandom();
        model_store(3'b010, addr, d);
        t_we = 1'b1; t_f3 = 3'b010; t_addr = addr; t_wdata = d;
        t_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_req_valid = 1'b0;
        chk("rst_store_pre_valid", 32'(cur_rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_store_valid", 32'(cur_rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        t_we = 1'b0; t_f3 = 3'b010; t_addr = addr;
        t_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_load_valid", 32'(cur_rsp_valid), 32'd0);
        chk("rst_load_rdata", cur_rsp_rdata, 32'd0);
        chk("rst_load_err", 32'(cur_rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(cur_rsp_valid), 32'd0);
            chk("rst_req_ready", 32'(cur_req_ready), 32'd1);
        end
        do_txn(1'b0, 3'b010, addr, 32'd0, 0, got);
        chk("rst_store_persist", got, d);
    endtask

    initial begin
        logic [31:0] got;
        sel = 1'b0;
        t_req_valid = 1'b0; t_we = 1'b0; t_f3 = 3'b000;
        t_addr = '0; t_wdata = '0; t_rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset_rsp_valid", 32'(cur_rsp_valid), 32'd0);
            chk("reset_rsp_rdata", cur_rsp_rdata, 32'd0);
            chk("reset_rsp_err", 32'(cur_rsp_err), 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset_req_ready", 32'(cur_req_ready), 32'd1);

            // Give the low 256 bytes known contents
            for (int w = 0; w < 64; w++) do_txn(1'b1, 3'b010, 12'(w * 4), $urandom(), 0, got);

            // Word round trip
            do_txn(1'b1, 3'b010, 12'h010, 32'h8000_0001, 0, got);
            do_txn(1'b0, 3'b010, 12'h010, 32'd0, 0, got);
            chk("t1_lw", got, 32'h8000_0001);

            // Byte store keeps other lanes
            do_txn(1'b1, 3'b010, 12'h020, 32'hAABB_CCDD, 0, got);
            do_txn(1'b1, 3'b000, 12'h022, 32'hFFFF_FF11, 0, got);
            do_txn(1'b0, 3'b010, 12'h020, 32'd0, 0, got);
            chk("t2_lw", got, 32'hAA11_CCDD);

            // Sign and zero extension
            do_txn(1'b1, 3'b010, 12'h030, 32'h80FF_7F01, 0, got);
            do_txn(1'b0, 3'b000, 12'h033, 32'd0, 0, got);
            chk("t3_lb", got, 32'hFFFF_FF80);
            do_txn(1'b0, 3'b100, 12'h033, 32'd0, 0, got);
            chk("t3_lbu", got, 32'h0000_0080);
            do_txn(1'b0, 3'b001, 12'h032, 32'd0, 0, got);
            chk("t3_lh", got, 32'hFFFF_80FF);
            do_txn(1'b0, 3'b101, 12'h030, 32'd0, 0, got);
            chk("t3_lhu", got, 32'h0000_7F01);

            // Errors leave memory untouched
            do_txn(1'b0, 3'b010, 12'h031, 32'd0, 0, got);
            do_txn(1'b1, 3'b001, 12'h033, 32'h0000_1234, 0, got);
            do_txn(1'b0, 3'b011, 12'h030, 32'd0, 0, got);
            do_txn(1'b1, 3'b011, 12'h030, 32'h1234_5678, 0, got);
            do_txn(1'b1, 3'b100, 12'h030, 32'h1234_5678, 0, got);
            do_txn(1'b1, 3'b010, 12'h032, 32'h1234_5678, 0, got);
            do_txn(1'b0, 3'b010, 12'h030, 32'd0, 0, got);
            chk("t4_unchanged", got, 32'h80FF_7F01);

            // Back-pressured response
            do_txn(1'b0, 3'b010, 12'h020, 32'd0, 5, got);
            chk("t5_held", got, 32'hAA11_CCDD);

            // Reset mid-operation
            reset_mid(12'h040);

            // Random mix against the reference memory
            for (int k = 0; k < 120; k++) begin
                do_txn(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       12'($urandom_range(0, 255)), $urandom(), $urandom_range(0, 2), got);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
